// File: rtl/booths_divider.sv
// Sequential signed divider: 2*WIDTH-bit dividend / WIDTH-bit divisor, radix-2 restoring on magnitudes.
// Optional EARLY_TERM_EN: zero divisor or zero dividend skips straight to DONE.
`timescale 1ns / 1ps

module booths_divider #(
    parameter int unsigned WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2*WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0]   divisor,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   quotient,
    output logic [WIDTH-1:0]   remainder,
    output logic               ovf,
    output logic               div_zero
);

    localparam int unsigned CW = $clog2(2 * WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(2 * WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

    state_e               state_q, state_d;
    logic [2*WIDTH-1:0]   dvd_q, dvd_d;
    logic [WIDTH-1:0]     dvs_q, dvs_d;
    logic [WIDTH:0]       rem_q, rem_d;
    logic [2*WIDTH-1:0]   quo_q, quo_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 dvd_neg_q, dvd_neg_d;
    logic                 dvs_neg_q, dvs_neg_d;
    logic                 dvs_zero_q, dvs_zero_d;
    logic [WIDTH-1:0]     dvd_lo_q, dvd_lo_d;
    logic [WIDTH-1:0]     quotient_q, quotient_d;
    logic [WIDTH-1:0]     remainder_q, remainder_d;
    logic                 ovf_q, ovf_d;
    logic                 div_zero_q, div_zero_d;

    logic [WIDTH:0]       rem_shift;
    logic                 rem_ge;
    logic [2*WIDTH-1:0]   q_signed;
    logic [WIDTH-1:0]     rem_signed;
    logic                 q_fits;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            dvd_q       <= '0;
            dvs_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            cnt_q       <= '0;
            dvd_neg_q   <= 1'b0;
            dvs_neg_q   <= 1'b0;
            dvs_zero_q  <= 1'b0;
            dvd_lo_q    <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            ovf_q       <= 1'b0;
            div_zero_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            dvd_q       <= dvd_d;
            dvs_q       <= dvs_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            cnt_q       <= cnt_d;
            dvd_neg_q   <= dvd_neg_d;
            dvs_neg_q   <= dvs_neg_d;
            dvs_zero_q  <= dvs_zero_d;
            dvd_lo_q    <= dvd_lo_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            ovf_q       <= ovf_d;
            div_zero_q  <= div_zero_d;
        end
    end

    always_comb begin
        // rem_q[WIDTH] is always 0 after a step; folding it in keeps the compare exact
        rem_shift  = {rem_q[WIDTH-1:0], dvd_q[2*WIDTH-1]};
        rem_ge     = rem_q[WIDTH] | (rem_shift >= {1'b0, dvs_q});
        q_signed   = (dvd_neg_q ^ dvs_neg_q) ? -quo_q : quo_q;
        rem_signed = dvd_neg_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
        // Fits in signed WIDTH when the top WIDTH+1 bits are a pure sign extension
        q_fits     = (&q_signed[2*WIDTH-1:WIDTH-1]) | ~(|q_signed[2*WIDTH-1:WIDTH-1]);
    end

    always_comb begin
        state_d     = state_q;
        dvd_d       = dvd_q;
        dvs_d       = dvs_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        cnt_d       = cnt_q;
        dvd_neg_d   = dvd_neg_q;
        dvs_neg_d   = dvs_neg_q;
        dvs_zero_d  = dvs_zero_q;
        dvd_lo_d    = dvd_lo_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        ovf_d       = ovf_q;
        div_zero_d  = div_zero_q;
        in_ready    = 1'b0;
        out_valid   = 1'b0;

        unique case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    dvd_d      = dividend[2*WIDTH-1] ? -dividend : dividend;
                    dvs_d      = divisor[WIDTH-1] ? -divisor : divisor;
                    dvd_neg_d  = dividend[2*WIDTH-1];
                    dvs_neg_d  = divisor[WIDTH-1];
                    dvs_zero_d = (divisor == '0);
                    dvd_lo_d   = dividend[WIDTH-1:0];
                    quo_d      = '0;
                    rem_d      = '0;
                    cnt_d      = '0;
                    state_d    = StCalc;
`ifdef EARLY_TERM_EN
                    if (divisor == '0) begin
                        quotient_d  = '1;
                        remainder_d = dividend[WIDTH-1:0];
                        ovf_d       = 1'b0;
                        div_zero_d  = 1'b1;
                        state_d     = StDone;
                    end else if (dividend == '0) begin
                        quotient_d  = '0;
                        remainder_d = '0;
                        ovf_d       = 1'b0;
                        div_zero_d  = 1'b0;
                        state_d     = StDone;
                    end
`endif
                end
            end
            StCalc: begin
                rem_d = rem_ge ? (rem_shift - {1'b0, dvs_q}) : rem_shift;
                quo_d = {quo_q[2*WIDTH-2:0], rem_ge};
                dvd_d = {dvd_q[2*WIDTH-2:0], 1'b0};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                if (dvs_zero_q) begin
                    quotient_d  = '1;
                    remainder_d = dvd_lo_q;
                    ovf_d       = 1'b0;
                    div_zero_d  = 1'b1;
                end else begin
                    quotient_d  = q_signed[WIDTH-1:0];
                    remainder_d = rem_signed;
                    ovf_d       = ~q_fits;
                    div_zero_d  = 1'b0;
                end
                state_d = StDone;
            end
            StDone: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign ovf       = ovf_q;
    assign div_zero  = div_zero_q;

endmodule
